elevator_state_ctrl: RTL and testbench
======================================

# elevator_state_ctrl

Parametrised elevator-simulation state block: snapshots per-floor waiting-passenger counts and per-car start floors on a load request, then holds and updates them each clock cycle. Per-floor remaining counters decrement on car pickups, and per-car floor and direction registers update on move commands. Sits between the stimulus/configuration front end and the car scheduler. It replaces the single-edge, fixed 7-floor/2-car loader with a clocked, N-floor/M-car controller that has arbitration and completion detection.

## Interface
- NUM_FLOORS, 7, number of floors; floor indices 0..NUM_FLOORS-1
- NUM_CARS, 2, number of elevator cars
- PASS_W, 6, width of a per-floor passenger count
- FLOOR_W, 3, width of a floor index; must satisfy 2^FLOOR_W >= NUM_FLOORS
- clk  in  1  system clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- load_start  in  1  single-cycle load request
- passenger_in  in  NUM_FLOORS*PASS_W  initial counts, floor f at bits [f*PASS_W +: PASS_W]
- init_floor_in  in  NUM_CARS*FLOOR_W  start floor per car, car c at [c*FLOOR_W +: FLOOR_W]
- pickup_valid  in  NUM_CARS  per-car pickup request
- pickup_floor  in  NUM_CARS*FLOOR_W  floor for each pickup request
- pickup_count  in  NUM_CARS*PASS_W  passengers requested per pickup
- pickup_ready  out  NUM_CARS  pickup accepted this cycle (combinational)
- pickup_taken  out  NUM_CARS*PASS_W  registered count actually removed, valid the cycle after acceptance
- move_valid  in  NUM_CARS  per-car one-floor move request
- remaining_out  out  NUM_FLOORS*PASS_W  current per-floor remaining counts
- curr_floor_out  out  NUM_CARS*FLOOR_W  current floor per car
- dir_out  out  NUM_CARS*2  per-car direction: 2'b10 up, 2'b01 down, 2'b00 idle
- busy  out  1  state is RUN
- all_served  out  1  state is DONE
- floor_err  out  1  sticky: a pickup named a floor >= NUM_FLOORS

## Operation
- States:
  - IDLE: entered from reset.
  - RUN: entered when load_start is sampled high in any state, including RUN and DONE (a mid-run reload discards all current state).
  - DONE: entered from RUN when every remaining count is 0 at a clock edge where no load is occurring.
- Load, on the edge that samples load_start high:
  - remaining[f] <= passenger_in field f.
  - curr_floor[c] <= init_floor_in field c, clamped to NUM_FLOORS-1.
  - dir[c] <= 2'b01 if the clamped start floor > (NUM_FLOORS-1)/2, else 2'b10.
  - floor_err and pickup_taken are cleared.
  - Pickups and moves presented on that cycle are ignored.
- pickup_ready[c] is high only when all of these hold:
  - state is RUN,
  - load_start is low,
  - pickup_valid[c] is high,
  - no lower-index car has pickup_valid high for the same floor.
- Accepted pickup on a valid floor f: remaining[f] <= remaining[f] - min(pickup_count, remaining[f]); pickup_taken[c] <= that minimum. Counters never wrap below 0.
- Accepted pickup on floor >= NUM_FLOORS: remaining unchanged, pickup_taken[c] <= 0, floor_err <= 1.
- Pickups by different cars on different floors in the same cycle are all applied.
- Moves, applied in RUN only with load_start low; move_valid is ignored when dir is 00:
  - dir 10 below the top floor: curr_floor +1.
  - dir 10 at the top floor: no move, dir <= 01.
  - dir 01 above floor 0: curr_floor -1.
  - dir 01 at floor 0: no move, dir <= 10.
- Entering DONE: all dir <= 2'b00; curr_floor is held.
- In IDLE and DONE, pickup_ready is 0 and moves are ignored.

## Timing
- Reset (reset_n low, asynchronous): state IDLE; remaining_out, curr_floor_out, dir_out, pickup_taken, busy, all_served, floor_err all 0.
- Load latency: outputs show loaded values on the edge that samples load_start; busy is 1 from that edge.
- Pickup: accepted at edge k; remaining_out and pickup_taken update at edge k.
- Move: sampled at edge k; curr_floor_out and dir_out update at edge k.
- DONE detection: on the first edge at which the registered remaining counts are all zero.
  - all_served rises one edge after the last accepted pickup.
  - A load of all-zero counts reaches DONE one edge after the load.
- A car's pickup and move in the same cycle both apply; the pickup uses pickup_floor, not curr_floor.

## Test plan
- Reset then load passengers {5,0,3,0,0,0,2}, cars at floors {4,1}: remaining_out matches, dir_out = {car1: 10, car0: 01}, busy=1.
- Car0 pickup floor 0, count 7, with remaining 5: pickup_taken=5, remaining[0]=0, no wrap.
- Cars 0 and 1 both pick up floor 2 in the same cycle: pickup_ready=2'b01; car1 is accepted the following cycle.
- Car1 at floor 6 with dir 10 and move_valid: floor stays 6, dir becomes 01; the next move gives floor 5.
- Pickup on floor 7 with NUM_FLOORS=7: floor_err=1, counts unchanged; drain all floors → all_served=1, dir_out all 00.
- load_start mid-RUN alongside a pickup: the pickup is ignored and the new snapshot is loaded; reset_n pulsed mid-RUN → all outputs return to 0 immediately.

Source files
------------

// File: rtl/elevator_state_ctrl.sv
// elevator_state_ctrl: N-floor/M-car passenger snapshot, pickup arbitration, car motion and completion detection
module elevator_state_ctrl #(
   parameter int NUM_FLOORS = 7,
   parameter int NUM_CARS   = 2,
   parameter int PASS_W     = 6,
   parameter int FLOOR_W    = 3
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           load_start,
   input  logic [NUM_FLOORS*PASS_W-1:0]   passenger_in,
   input  logic [NUM_CARS*FLOOR_W-1:0]    init_floor_in,
   input  logic [NUM_CARS-1:0]            pickup_valid,
   input  logic [NUM_CARS*FLOOR_W-1:0]    pickup_floor,
   input  logic [NUM_CARS*PASS_W-1:0]     pickup_count,
   output logic [NUM_CARS-1:0]            pickup_ready,
   output logic [NUM_CARS*PASS_W-1:0]     pickup_taken,
   input  logic [NUM_CARS-1:0]            move_valid,
   output logic [NUM_FLOORS*PASS_W-1:0]   remaining_out,
   output logic [NUM_CARS*FLOOR_W-1:0]    curr_floor_out,
   output logic [NUM_CARS*2-1:0]          dir_out,
   output logic                           busy,
   output logic                           all_served,
   output logic                           floor_err
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic [FLOOR_W-1:0] TOP = FLOOR_W'(NUM_FLOORS - 1);
   localparam logic [FLOOR_W-1:0] MID = FLOOR_W'((NUM_FLOORS - 1) / 2);
   state_t                        state_q, state_d;
   logic [NUM_FLOORS*PASS_W-1:0]  rem_q, rem_d;
   logic [NUM_CARS*FLOOR_W-1:0]   floor_q, floor_d;
   logic [NUM_CARS*2-1:0]         dir_q, dir_d;
   logic [NUM_CARS*PASS_W-1:0]    taken_q, taken_d;
   logic                          err_q, err_d, busy_q, busy_d, served_q, served_d;
   logic [NUM_CARS-1:0]           ready;
   logic [FLOOR_W-1:0]            fl, pf;
   logic [PASS_W-1:0]             pc, rv, amt;
   logic                          active;
   assign active         = (state_q == RUN) && !load_start;
   assign pickup_ready   = ready;
   assign pickup_taken   = taken_q;
   assign remaining_out  = rem_q;
   assign curr_floor_out = floor_q;
   assign dir_out        = dir_q;
   assign busy           = busy_q;
   assign all_served     = served_q;
   assign floor_err      = err_q;
   // Arbitration: a floor requested by several cars goes to the lowest-index one
   always_comb begin
      ready = '0;
      for (int c = 0; c < NUM_CARS; c++) begin
         ready[c] = active && pickup_valid[c];
         for (int j = 0; j < c; j++)
            if (pickup_valid[j] && pickup_floor[j*FLOOR_W +: FLOOR_W] == pickup_floor[c*FLOOR_W +: FLOOR_W])
               ready[c] = 1'b0;
      end
   end
   // Next state: load snapshot, apply saturating pickups, then moves or completion
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      floor_d = floor_q;
      dir_d   = dir_q;
      taken_d = '0;
      err_d   = err_q;
      fl      = '0;
      pf      = '0;
      pc      = '0;
      rv      = '0;
      amt     = '0;
      if (load_start) begin
         state_d = RUN;
         rem_d   = passenger_in;
         err_d   = 1'b0;
         for (int c = 0; c < NUM_CARS; c++) begin
            fl = init_floor_in[c*FLOOR_W +: FLOOR_W];
            fl = (fl > TOP) ? TOP : fl;
            floor_d[c*FLOOR_W +: FLOOR_W] = fl;
            dir_d[c*2 +: 2] = (fl > MID) ? 2'b01 : 2'b10;
         end
      end else if (state_q == RUN) begin
         for (int c = 0; c < NUM_CARS; c++) begin
            pf = pickup_floor[c*FLOOR_W +: FLOOR_W];
            pc = pickup_count[c*PASS_W +: PASS_W];
            if (ready[c] && pf > TOP)
               err_d = 1'b1;
            for (int f = 0; f < NUM_FLOORS; f++)
               if (ready[c] && pf == FLOOR_W'(f)) begin
                  rv  = rem_q[f*PASS_W +: PASS_W];
                  amt = (pc < rv) ? pc : rv;
                  rem_d[f*PASS_W +: PASS_W] = rv - amt;
                  taken_d[c*PASS_W +: PASS_W] = amt;
               end
         end
         if (rem_q == '0) begin
            state_d = DONE;
            dir_d   = '0;
         end else begin
            for (int c = 0; c < NUM_CARS; c++) begin
               fl = floor_q[c*FLOOR_W +: FLOOR_W];
               if (move_valid[c] && dir_q[c*2 +: 2] == 2'b10) begin
                  if (fl == TOP) dir_d[c*2 +: 2] = 2'b01;
                  else floor_d[c*FLOOR_W +: FLOOR_W] = fl + 1'b1;
               end else if (move_valid[c] && dir_q[c*2 +: 2] == 2'b01) begin
                  if (fl == '0) dir_d[c*2 +: 2] = 2'b10;
                  else floor_d[c*FLOOR_W +: FLOOR_W] = fl - 1'b1;
               end
            end
         end
      end
      busy_d   = (state_d == RUN);
      served_d = (state_d == DONE);
   end
   // State and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         rem_q    <= '0;
         floor_q  <= '0;
         dir_q    <= '0;
         taken_q  <= '0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         served_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rem_q    <= rem_d;
         floor_q  <= floor_d;
         dir_q    <= dir_d;
         taken_q  <= taken_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
         served_q <= served_d;
      end
   end
endmodule

// File: tb/tb_elevator_state_ctrl.sv
// tb_elevator_state_ctrl: directed scenarios plus random traffic against a floor/car reference model
module tb_elevator_state_ctrl;
   localparam int NF = 7;
   localparam int NC = 2;
   localparam int PW = 6;
   localparam int FW = 3;
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic load_start = 1'b0;
   logic [NF*PW-1:0] passenger_in = '0;
   logic [NC*FW-1:0] init_floor_in = '0;
   logic [NC-1:0] pickup_valid = '0;
   logic [NC*FW-1:0] pickup_floor = '0;
   logic [NC*PW-1:0] pickup_count = '0;
   logic [NC-1:0] pickup_ready;
   logic [NC*PW-1:0] pickup_taken;
   logic [NC-1:0] move_valid = '0;
   logic [NF*PW-1:0] remaining_out;
   logic [NC*FW-1:0] curr_floor_out;
   logic [NC*2-1:0] dir_out;
   logic busy, all_served, floor_err;
   int checks = 0;
   int failures = 0;
   int m_rem[NF];
   int m_fl[NC];
   int m_dir[NC];
   int m_take[NC];
   bit m_acc[NC];
   int m_mode;
   bit m_err;
   always #5 clk = ~clk;
   elevator_state_ctrl #(.NUM_FLOORS(NF), .NUM_CARS(NC), .PASS_W(PW), .FLOOR_W(FW)) dut (
      .clk(clk), .reset_n(reset_n), .load_start(load_start), .passenger_in(passenger_in),
      .init_floor_in(init_floor_in), .pickup_valid(pickup_valid), .pickup_floor(pickup_floor),
      .pickup_count(pickup_count), .pickup_ready(pickup_ready), .pickup_taken(pickup_taken),
      .move_valid(move_valid), .remaining_out(remaining_out), .curr_floor_out(curr_floor_out),
      .dir_out(dir_out), .busy(busy), .all_served(all_served), .floor_err(floor_err));
   function automatic logic [NF*PW-1:0] pack7(input int a, b, c, d, e, f, g);
      int v[NF];
      logic [NF*PW-1:0] r;
      v = '{a, b, c, d, e, f, g};
      r = '0;
      for (int i = 0; i < NF; i++) r[i*PW +: PW] = PW'(v[i]);
      return r;
   endfunction
   function automatic int pfl(input int c);
      return int'(pickup_floor[c*FW +: FW]);
   endfunction
   function automatic logic [NF*PW-1:0] e_rem();
      logic [NF*PW-1:0] r = '0;
      for (int i = 0; i < NF; i++) r[i*PW +: PW] = PW'(m_rem[i]);
      return r;
   endfunction
   function automatic logic [NC*FW-1:0] e_floor();
      logic [NC*FW-1:0] r = '0;
      for (int i = 0; i < NC; i++) r[i*FW +: FW] = FW'(m_fl[i]);
      return r;
   endfunction
   function automatic logic [NC*2-1:0] e_dir();
      logic [NC*2-1:0] r = '0;
      for (int i = 0; i < NC; i++) r[i*2 +: 2] = (m_dir[i] > 0) ? 2'b10 : (m_dir[i] < 0) ? 2'b01 : 2'b00;
      return r;
   endfunction
   function automatic logic [NC*PW-1:0] e_taken();
      logic [NC*PW-1:0] r = '0;
      for (int i = 0; i < NC; i++) r[i*PW +: PW] = PW'(m_take[i]);
      return r;
   endfunction
   function automatic logic [NC*PW-1:0] e_mask();
      logic [NC*PW-1:0] r = '0;
      for (int i = 0; i < NC; i++) if (m_acc[i]) r[i*PW +: PW] = '1;
      return r;
   endfunction
   function automatic logic [NC-1:0] m_ready();
      logic [NC-1:0] r = '0;
      for (int c = 0; c < NC; c++) begin
         bit blocked = 0;
         for (int j = 0; j < c; j++) if (pickup_valid[j] && pfl(j) == pfl(c)) blocked = 1;
         r[c] = (m_mode == M_RUN) && !load_start && pickup_valid[c] && !blocked;
      end
      return r;
   endfunction
   task automatic model_reset();
      for (int i = 0; i < NF; i++) m_rem[i] = 0;
      for (int i = 0; i < NC; i++) begin m_fl[i] = 0; m_dir[i] = 0; m_take[i] = 0; m_acc[i] = 0; end
      m_mode = M_IDLE;
      m_err = 0;
   endtask
   task automatic model_step();
      logic [NC-1:0] rdy;
      int total, f, amt;
      rdy = m_ready();
      for (int c = 0; c < NC; c++) begin m_acc[c] = 0; m_take[c] = 0; end
      if (load_start) begin
         for (int i = 0; i < NF; i++) m_rem[i] = int'(passenger_in[i*PW +: PW]);
         for (int c = 0; c < NC; c++) begin
            m_fl[c] = int'(init_floor_in[c*FW +: FW]);
            if (m_fl[c] > NF - 1) m_fl[c] = NF - 1;
            m_dir[c] = (m_fl[c] > (NF - 1) / 2) ? -1 : 1;
         end
         m_err = 0;
         m_mode = M_RUN;
      end else if (m_mode == M_RUN) begin
         total = 0;
         for (int i = 0; i < NF; i++) total += m_rem[i];
         for (int c = 0; c < NC; c++) if (rdy[c]) begin
            m_acc[c] = 1;
            f = pfl(c);
            if (f >= NF) m_err = 1;
            else begin
               amt = int'(pickup_count[c*PW +: PW]);
               if (amt > m_rem[f]) amt = m_rem[f];
               m_rem[f] -= amt;
               m_take[c] = amt;
            end
         end
         if (total == 0) begin
            m_mode = M_DONE;
            for (int c = 0; c < NC; c++) m_dir[c] = 0;
         end else for (int c = 0; c < NC; c++) if (move_valid[c]) begin
            if (m_dir[c] > 0) begin
               if (m_fl[c] == NF - 1) m_dir[c] = -1; else m_fl[c]++;
            end else if (m_dir[c] < 0) begin
               if (m_fl[c] == 0) m_dir[c] = 1; else m_fl[c]--;
            end
         end
      end
   endtask
   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask
   task automatic idle_inputs();
      load_start = 0;
      pickup_valid = '0;
      move_valid = '0;
   endtask
   task automatic test_reset();
      reset_n = 0;
      pickup_valid = '1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({remaining_out, curr_floor_out, dir_out, pickup_taken, busy, all_served, floor_err} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got rem=%h fl=%h dir=%h tk=%h busy=%b srv=%b err=%b, expected all 0", remaining_out, curr_floor_out, dir_out, pickup_taken, busy, all_served, floor_err);
      end
      checks++;
      if (pickup_ready !== '0) begin failures++; $display("FAIL reset_ready: got %b expected 00", pickup_ready); end
      @(negedge clk);
      reset_n = 1;
      pickup_valid = '0;
      move_valid = '1;
      tick();
      checks++;
      if (busy !== 1'b0 || curr_floor_out !== '0 || dir_out !== '0) begin
         failures++;
         $display("FAIL idle_hold: got busy=%b fl=%h dir=%h expected 0 0 0", busy, curr_floor_out, dir_out);
      end
      idle_inputs();
   endtask
   task automatic test_load();
      passenger_in = pack7(5, 0, 3, 0, 0, 0, 2);
      init_floor_in = {3'd1, 3'd4};
      load_start = 1;
      tick();
      idle_inputs();
      checks++;
      if (remaining_out !== pack7(5, 0, 3, 0, 0, 0, 2)) begin failures++; $display("FAIL load_remaining: got %h expected %h", remaining_out, pack7(5, 0, 3, 0, 0, 0, 2)); end
      checks++;
      if (dir_out !== 4'b10_01) begin failures++; $display("FAIL load_dir: got %b expected 1001", dir_out); end
      checks++;
      if (curr_floor_out !== {3'd1, 3'd4} || busy !== 1'b1 || all_served !== 1'b0) begin
         failures++;
         $display("FAIL load_floor_busy: got fl=%h busy=%b srv=%b expected fl=%h busy=1 srv=0", curr_floor_out, busy, all_served, {3'd1, 3'd4});
      end
   endtask
   task automatic test_pickup_saturate();
      pickup_valid = 2'b01;
      pickup_floor = {3'd0, 3'd0};
      pickup_count = {6'd0, 6'd7};
      @(negedge clk);
      checks++;
      if (pickup_ready !== 2'b01) begin failures++; $display("FAIL sat_ready: got %b expected 01", pickup_ready); end
      tick();
      idle_inputs();
      checks++;
      if (pickup_taken[PW-1:0] !== 6'd5) begin failures++; $display("FAIL sat_taken: got %0d expected 5", pickup_taken[PW-1:0]); end
      checks++;
      if (remaining_out !== pack7(0, 0, 3, 0, 0, 0, 2)) begin failures++; $display("FAIL sat_remaining: got %h expected %h", remaining_out, pack7(0, 0, 3, 0, 0, 0, 2)); end
   endtask
   task automatic test_arbitration();
      pickup_valid = 2'b11;
      pickup_floor = {3'd2, 3'd2};
      pickup_count = {6'd1, 6'd1};
      @(negedge clk);
      checks++;
      if (pickup_ready !== 2'b01) begin failures++; $display("FAIL arb_ready: got %b expected 01", pickup_ready); end
      tick();
      checks++;
      if (remaining_out !== pack7(0, 0, 2, 0, 0, 0, 2) || pickup_taken !== {6'd0, 6'd1}) begin
         failures++;
         $display("FAIL arb_first: got rem=%h tk=%h expected rem=%h tk=%h", remaining_out, pickup_taken, pack7(0, 0, 2, 0, 0, 0, 2), {6'd0, 6'd1});
      end
      pickup_valid = 2'b10;
      @(negedge clk);
      checks++;
      if (pickup_ready !== 2'b10) begin failures++; $display("FAIL arb_second_ready: got %b expected 10", pickup_ready); end
      tick();
      idle_inputs();
      checks++;
      if (remaining_out !== pack7(0, 0, 1, 0, 0, 0, 2) || pickup_taken[2*PW-1:PW] !== 6'd1) begin
         failures++;
         $display("FAIL arb_second: got rem=%h tk1=%0d expected rem=%h tk1=1", remaining_out, pickup_taken[2*PW-1:PW], pack7(0, 0, 1, 0, 0, 0, 2));
      end
   endtask
   task automatic test_move_bounce();
      move_valid = 2'b10;
      repeat (5) tick();
      checks++;
      if (curr_floor_out !== {3'd6, 3'd4} || dir_out !== 4'b10_01) begin failures++; $display("FAIL move_up: got fl=%h dir=%b expected fl=%h dir=1001", curr_floor_out, dir_out, {3'd6, 3'd4}); end
      tick();
      checks++;
      if (curr_floor_out !== {3'd6, 3'd4} || dir_out !== 4'b01_01) begin failures++; $display("FAIL move_top_turn: got fl=%h dir=%b expected fl=%h dir=0101", curr_floor_out, dir_out, {3'd6, 3'd4}); end
      tick();
      idle_inputs();
      checks++;
      if (curr_floor_out !== {3'd5, 3'd4} || dir_out !== 4'b01_01) begin failures++; $display("FAIL move_down: got fl=%h dir=%b expected fl=%h dir=0101", curr_floor_out, dir_out, {3'd5, 3'd4}); end
   endtask
   task automatic test_floor_err_drain();
      pickup_valid = 2'b01;
      pickup_floor = {3'd0, 3'd7};
      pickup_count = {6'd0, 6'd3};
      @(negedge clk);
      checks++;
      if (pickup_ready !== 2'b01) begin failures++; $display("FAIL err_ready: got %b expected 01", pickup_ready); end
      tick();
      checks++;
      if (floor_err !== 1'b1 || remaining_out !== pack7(0, 0, 1, 0, 0, 0, 2) || pickup_taken !== '0) begin
         failures++;
         $display("FAIL err_floor: got err=%b rem=%h tk=%h expected err=1 rem=%h tk=0", floor_err, remaining_out, pickup_taken, pack7(0, 0, 1, 0, 0, 0, 2));
      end
      pickup_valid = 2'b11;
      pickup_floor = {3'd6, 3'd2};
      pickup_count = {6'd5, 6'd1};
      @(negedge clk);
      checks++;
      if (pickup_ready !== 2'b11) begin failures++; $display("FAIL drain_ready: got %b expected 11", pickup_ready); end
      tick();
      idle_inputs();
      checks++;
      if (remaining_out !== '0 || pickup_taken !== {6'd2, 6'd1} || busy !== 1'b1 || all_served !== 1'b0) begin
         failures++;
         $display("FAIL drain_pickups: got rem=%h tk=%h busy=%b srv=%b expected rem=0 tk=%h busy=1 srv=0", remaining_out, pickup_taken, busy, all_served, {6'd2, 6'd1});
      end
      move_valid = 2'b11;
      tick();
      idle_inputs();
      checks++;
      if (all_served !== 1'b1 || busy !== 1'b0 || dir_out !== '0 || curr_floor_out !== {3'd5, 3'd4} || floor_err !== 1'b1) begin
         failures++;
         $display("FAIL done_state: got srv=%b busy=%b dir=%b fl=%h err=%b expected 1 0 0000 %h 1", all_served, busy, dir_out, curr_floor_out, floor_err, {3'd5, 3'd4});
      end
      pickup_valid = 2'b01;
      pickup_floor = '0;
      @(negedge clk);
      checks++;
      if (pickup_ready !== 2'b00) begin failures++; $display("FAIL done_ready: got %b expected 00", pickup_ready); end
      idle_inputs();
   endtask
   task automatic test_zero_load();
      passenger_in = '0;
      init_floor_in = {3'd3, 3'd0};
      load_start = 1;
      tick();
      idle_inputs();
      checks++;
      if (busy !== 1'b1 || all_served !== 1'b0 || floor_err !== 1'b0 || dir_out !== 4'b10_10) begin
         failures++;
         $display("FAIL zero_load: got busy=%b srv=%b err=%b dir=%b expected 1 0 0 1010", busy, all_served, floor_err, dir_out);
      end
      tick();
      checks++;
      if (all_served !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL zero_done: got srv=%b busy=%b expected 1 0", all_served, busy); end
   endtask
   task automatic test_reload_and_reset();
      passenger_in = pack7(1, 2, 3, 4, 5, 6, 7);
      init_floor_in = {3'd0, 3'd7};
      load_start = 1;
      tick();
      checks++;
      if (curr_floor_out !== {3'd0, 3'd6} || dir_out !== 4'b10_01) begin failures++; $display("FAIL reload_clamp: got fl=%h dir=%b expected fl=%h dir=1001", curr_floor_out, dir_out, {3'd0, 3'd6}); end
      passenger_in = pack7(9, 8, 7, 6, 5, 4, 3);
      init_floor_in = {3'd5, 3'd2};
      pickup_valid = 2'b01;
      pickup_floor = '0;
      pickup_count = {6'd0, 6'd4};
      @(negedge clk);
      checks++;
      if (pickup_ready !== 2'b00) begin failures++; $display("FAIL reload_ready: got %b expected 00", pickup_ready); end
      tick();
      idle_inputs();
      checks++;
      if (remaining_out !== pack7(9, 8, 7, 6, 5, 4, 3) || pickup_taken !== '0 || curr_floor_out !== {3'd5, 3'd2}) begin
         failures++;
         $display("FAIL reload_snapshot: got rem=%h tk=%h fl=%h expected rem=%h tk=0 fl=%h", remaining_out, pickup_taken, curr_floor_out, pack7(9, 8, 7, 6, 5, 4, 3), {3'd5, 3'd2});
      end
      #3 reset_n = 0;
      #1;
      model_reset();
      checks++;
      if ({remaining_out, curr_floor_out, dir_out, pickup_taken, busy, all_served, floor_err} !== '0) begin
         failures++;
         $display("FAIL async_reset: got rem=%h fl=%h dir=%h busy=%b expected all 0", remaining_out, curr_floor_out, dir_out, busy);
      end
      @(negedge clk);
      reset_n = 1;
   endtask
   task automatic test_random();
      logic [NC-1:0] er;
      for (int n = 0; n < 400; n++) begin
         load_start = (n == 0) || ($urandom_range(0, 29) == 0);
         for (int i = 0; i < NF; i++) passenger_in[i*PW +: PW] = PW'($urandom_range(0, 4));
         for (int c = 0; c < NC; c++) begin
            init_floor_in[c*FW +: FW] = FW'($urandom_range(0, 7));
            pickup_floor[c*FW +: FW] = FW'($urandom_range(0, 7));
            pickup_count[c*PW +: PW] = PW'($urandom_range(0, 6));
         end
         pickup_valid = NC'($urandom);
         move_valid = NC'($urandom);
         @(negedge clk);
         er = m_ready();
         checks++;
         if (pickup_ready !== er) begin failures++; $display("FAIL rnd_ready[%0d]: got %b expected %b", n, pickup_ready, er); end
         tick();
         checks++;
         if (remaining_out !== e_rem() || curr_floor_out !== e_floor() || dir_out !== e_dir()) begin
            failures++;
            $display("FAIL rnd_state[%0d]: got rem=%h fl=%h dir=%b expected rem=%h fl=%h dir=%b", n, remaining_out, curr_floor_out, dir_out, e_rem(), e_floor(), e_dir());
         end
         checks++;
         if (busy !== (m_mode == M_RUN) || all_served !== (m_mode == M_DONE) || floor_err !== m_err) begin
            failures++;
            $display("FAIL rnd_flags[%0d]: got busy=%b srv=%b err=%b expected %b %b %b", n, busy, all_served, floor_err, m_mode == M_RUN, m_mode == M_DONE, m_err);
         end
         if (e_mask() != '0) begin
            checks++;
            if ((pickup_taken & e_mask()) !== e_taken()) begin
               failures++;
               $display("FAIL rnd_taken[%0d]: got %h expected %h", n, pickup_taken & e_mask(), e_taken());
            end
         end
      end
      idle_inputs();
   endtask
   initial begin
      test_reset();
      test_load();
      test_pickup_saturate();
      test_arbitration();
      test_move_bounce();
      test_floor_err_drain();
      test_zero_load();
      test_reload_and_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
